// File: rtl/clk_prescaler.sv
// Table-driven clock-enable prescaler: fetches a divide value from an external
// ROM, then emits a one-cycle tick every div_cur+1 enabled cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   FETCH | one cycle; rom_ad presents sel_reg, div_cur loaded at its end
//   RUN   | counting; requests accepted, tick at terminal count
module clk_prescaler #(
    parameter int DIV_W = 24,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic             en,
    output logic [SEL_W-1:0] rom_ad,
    input  logic [DIV_W-1:0] rom_dout,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur,
    output logic             loaded
);

    typedef enum logic {
        FETCH = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] sel_reg;
    logic [DIV_W-1:0] cnt;
    logic             accept;
    logic             at_tc;

    // The ROM address is the latched index register itself.
    assign rom_ad = sel_reg;

    always_comb begin
        state_nx  = state;
        sel_ready = 1'b0;
        tick      = 1'b0;
        accept    = 1'b0;
        at_tc     = (cnt == div_cur);
        case (state)
            FETCH: state_nx = RUN;
            RUN: begin
                sel_ready = 1'b1;
                tick      = en && at_tc;
                accept    = sel_valid;
                if (accept)
                    state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            sel_reg <= '0;
            cnt     <= '0;
            div_cur <= '0;
            loaded  <= 1'b0;
        end else begin
            state  <= state_nx;
            loaded <= (state == FETCH);
            if (state == FETCH) begin
                div_cur <= rom_dout;
                cnt     <= '0;
            end else if (accept) begin
                // Count is restarted by the following FETCH, so it is left as is.
                sel_reg <= sel;
            end else if (en) begin
                cnt <= at_tc ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_prescaler.sv
// Randomized self-checking bench for clk_prescaler; expected outputs come from a
// model that predicts ticks from the number of enabled cycles since each load.
module tb_clk_prescaler;

    localparam int DIV_W = 24;
    localparam int SEL_W = 4;
    localparam int VW    = 3 + SEL_W + DIV_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sel_ready;
    logic             en;
    logic [SEL_W-1:0] rom_ad;
    logic [DIV_W-1:0] rom_dout;
    logic             tick;
    logic [DIV_W-1:0] div_cur;
    logic             loaded;

    logic [DIV_W-1:0] rom_arr [16];
    assign rom_dout = rom_arr[rom_ad];

    always #5 clk = ~clk;

    clk_prescaler #(.DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .en        (en),
        .rom_ad    (rom_ad),
        .rom_dout  (rom_dout),
        .tick      (tick),
        .div_cur   (div_cur),
        .loaded    (loaded)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_ticks  = 0;

    // Reference model: fetch flag, latched index, divide value, enabled cycles since load.
    bit               m_fetch;
    bit               m_loaded;
    logic [SEL_W-1:0] m_ad;
    longint           m_div;
    longint           m_elapsed;

    function automatic logic exp_tick();
        return !m_fetch && en && ((m_elapsed % (m_div + 1)) == m_div);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [DIV_W-1:0] d;
        d = m_div[DIV_W-1:0];
        return {!m_fetch, exp_tick(), m_loaded, m_ad, d};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {sel_ready, tick, loaded, rom_ad, div_cur};
    endfunction

    // Advance one clock; the model consumes the inputs held across the edge.
    task automatic step();
        @(posedge clk);
        if (tick === 1'b1) n_ticks++;
        if (rst) begin
            m_fetch = 1; m_ad = '0; m_div = 0; m_elapsed = 0; m_loaded = 0;
        end else if (m_fetch) begin
            m_div = longint'(rom_arr[m_ad]); m_elapsed = 0; m_fetch = 0; m_loaded = 1;
        end else begin
            m_loaded = 0;
            if (sel_valid) begin
                m_fetch = 1; m_ad = sel;
            end else if (en) begin
                m_elapsed++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; sel = '0; sel_valid = 0; en = 1;
        step(); step();
        #1;
        n_checks++;
        if (obs_vec() !== '0)
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), {VW{1'b0}});
        else n_pass++;
        rst = 0;
        // V-1: fetch of index 0 (divide 0), then tick every cycle
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v1_auto_start cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            step();
        end
        n_checks++;
        if (tick !== 1'b1 || div_cur !== '0)
            $display("FAIL v1_tick_every_cycle tick=%b div=%h exp tick=1 div=0", tick, div_cur);
        else n_pass++;
    endtask

    task automatic test_div8();
        int first_tick;
        int t_loaded;
        first_tick = -1; t_loaded = -1;
        sel = 4'd4; sel_valid = 1; en = 1;
        for (int i = 0; i < 30; i++) begin
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v2_div8 cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (loaded === 1'b1) t_loaded = i;
            if (tick === 1'b1 && t_loaded >= 0 && first_tick < 0) first_tick = i;
            step();
            sel_valid = 0;
        end
        n_checks++;
        if (first_tick - t_loaded !== 8)
            $display("FAIL v2_first_tick_latency got=%0d exp=8", first_tick - t_loaded);
        else n_pass++;
    endtask

    task automatic test_en_stall();
        sel = 4'd2; sel_valid = 1; en = 1;
        for (int i = 0; i < 24; i++) begin
            en = !(i >= 9 && i < 12);
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v3_en_stall cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (!en) begin
                n_checks++;
                if (tick !== 1'b0) $display("FAIL v3_no_tick_when_disabled got=%b exp=0", tick);
                else n_pass++;
            end
            step();
            sel_valid = 0;
        end
        en = 1;
    endtask

    task automatic test_accept_on_tick();
        bit hit;
        hit = 0;
        sel = 4'd1; sel_valid = 1; en = 1;
        step(); sel_valid = 0;
        step(); step();
        for (int i = 0; i < 10 && !hit; i++) begin
            #1;
            if (exp_tick()) hit = 1;
            else step();
        end
        n_checks++;
        if (!hit) $display("FAIL v4_tick_wait got=timeout exp=tick");
        else n_pass++;
        sel = 4'd4; sel_valid = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v4_accept_on_tick cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (tick !== 1'b1) $display("FAIL v4_tick_kept got=%b exp=1", tick);
                else n_pass++;
            end
            step();
            sel_valid = 0;
        end
    endtask

    task automatic test_ignore_in_fetch();
        sel = 4'd2; sel_valid = 1;
        step();
        sel = 4'd9;
        #1;
        n_checks++;
        if (sel_ready !== 1'b0 || rom_ad !== 4'd2)
            $display("FAIL v5_fetch_state ready=%b ad=%h exp ready=0 ad=2", sel_ready, rom_ad);
        else n_pass++;
        step();
        sel_valid = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v5_ignore_in_fetch cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            step();
        end
        n_checks++;
        if (rom_ad !== 4'd2) $display("FAIL v5_rom_ad_held got=%h exp=2", rom_ad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        sel = 4'd15; sel_valid = 1;
        for (int i = 0; i < 30; i++) begin
            rst = (i == 12 || i == 13);
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL v6_reset_mid cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            step();
            sel_valid = 0;
            if (i == 13) begin
                #1;
                n_checks++;
                if (obs_vec() !== '0)
                    $display("FAIL v6_reset_values got=%h exp=0", obs_vec());
                else n_pass++;
            end
        end
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            sel_valid = ($urandom_range(0, 7) == 0);
            sel       = SEL_W'($urandom_range(0, 15));
            en        = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            else n_pass++;
            step();
        end
        rst = 0; sel_valid = 0; en = 1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_arr[i] = DIV_W'($urandom_range(0, 6));
        rom_arr[0]  = 24'h000000;
        rom_arr[1]  = 24'h000001;
        rom_arr[2]  = 24'h000001;
        rom_arr[4]  = 24'h000008;
        rom_arr[15] = 24'hCDFE5F;
        test_reset();
        test_div8();
        test_en_stall();
        test_accept_on_tick();
        test_ignore_in_fetch();
        test_reset_mid();
        test_random();
        n_checks++;
        if (n_ticks == 0) $display("FAIL tick_activity got=0 exp=nonzero");
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_prescaler.md
CLK_PRESCALER -- requirements
Module: clk_prescaler

Interface
REQ-001 Parameter DIV_W, default 24, SHALL set the divide-value, counter and ROM data width.
REQ-002 Parameter SEL_W, default 4, SHALL set the divide-table index and ROM address width.
REQ-003 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 sel  input  SEL_W: requested divide-table index.
REQ-006 sel_valid  input  1: request to load the divide value at index sel.
REQ-007 sel_ready  output  1: high when a request can be accepted.
REQ-008 en  input  1: count enable; low freezes the counter.
REQ-009 rom_ad  output  SEL_W: registered address to the combinational divide-value ROM.
REQ-010 rom_dout  input  DIV_W: ROM data; valid in the same cycle as rom_ad.
REQ-011 tick  output  1: prescaled clock-enable pulse.
REQ-012 div_cur  output  DIV_W: divide value currently in use.
REQ-013 loaded  output  1: one-cycle pulse when a new divide value takes effect.

Function
REQ-014 The block SHALL have two states: FETCH and RUN.
REQ-015 In FETCH, rom_ad SHALL equal the latched index (sel_reg), sel_ready SHALL be 0 and tick SHALL be 0.
REQ-016 FETCH SHALL last exactly one cycle; at its end div_cur <= rom_dout, cnt <= 0, state <= RUN.
REQ-017 loaded SHALL be 1 in the first RUN cycle after every FETCH and 0 otherwise.
REQ-018 In RUN, sel_ready SHALL be 1.
REQ-019 tick SHALL equal (state==RUN && en && cnt==div_cur), decoded from registered state only.
REQ-020 In RUN with en=1, cnt SHALL reset to 0 when cnt==div_cur and increment otherwise; the tick period is therefore div_cur+1 cycles.
REQ-021 div_cur=0 SHALL produce tick=1 on every RUN cycle with en=1.
REQ-022 In RUN with en=0, cnt SHALL hold and tick SHALL be 0; counting resumes from the held value.
REQ-023 cnt SHALL be DIV_W bits wide; div_cur=all-ones SHALL give a period of 2^DIV_W cycles with no overflow.
REQ-024 A request SHALL be accepted when sel_valid && sel_ready; then sel_reg <= sel and state <= FETCH.
REQ-025 If a tick and an accepted request occur in the same cycle, tick SHALL still be asserted in that cycle, and counting SHALL restart only after the FETCH.
REQ-026 sel_valid SHALL be ignored in FETCH; sel SHALL not be sampled.
REQ-027 A request for the already-loaded index SHALL still perform FETCH and restart the count.
REQ-028 rom_ad SHALL be a registered copy of sel_reg and SHALL change only on acceptance or reset.

Reset
REQ-029 While rst=1: state=FETCH, sel_reg=0, rom_ad=0, cnt=0, div_cur=0, tick=0, loaded=0, sel_ready=0.
REQ-030 On the first cycle after rst falls, the block SHALL perform a FETCH of index 0 (auto-start).
REQ-031 Reset asserted mid-RUN or mid-FETCH SHALL abandon the operation and take effect on the next edge; no tick SHALL occur during reset.

Verification
V-1 Reset release, ROM index 0 = 0x000000, en=1: one FETCH cycle, loaded pulse, then tick=1 on every cycle.
V-2 Request sel=4 (ROM 0x000008): sel_ready low for 1 cycle, rom_ad=4, div_cur=8, first tick 8 cycles after loaded, then every 9 cycles.
V-3 sel=2 (ROM 0x000001) running, en low for 3 cycles mid-period: tick period stretches by exactly 3 cycles and no tick occurs while en=0.
V-4 Request accepted in the same cycle as a tick (div 1): that tick is observed, followed by one FETCH cycle, then the new period.
V-5 sel_valid held during FETCH with a different sel: the second value is ignored, and rom_ad changes only on accepted requests.
V-6 sel=15 (ROM 0xCDFE5F), rst pulsed mid-count: outputs reach their REQ-029 values, and index 0 is fetched after release.
